// File: rtl/fir_decim_multi.sv
// Multi-channel decimating FIR: one tap per cycle, all lanes in lock-step.
// Input words that arrive during compute are staged and merged into the history when the output is written.
module fir_decim_multi #(
  parameter int TAP_NUMBER = 32,
  parameter int DECIMATION = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int FRAC_BITS  = 10,
  parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] CONV_COEFF = {
    32'd8,   32'd16,  32'd28,  32'd44,  32'd64,  32'd86,  32'd110, 32'd134,
    32'd158, 32'd180, 32'd200, 32'd218, 32'd232, 32'd244, 32'd266, 32'd272,
    32'd272, 32'd266, 32'd244, 32'd232, 32'd218, 32'd200, 32'd180, 32'd158,
    32'd134, 32'd110, 32'd86,  32'd64,  32'd44,  32'd28,  32'd16,  32'd8
  }
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_dout,
  input  logic                           in_empty,
  output logic                           in_rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_din,
  output logic                           out_wr_en,
  input  logic                           out_full
);

  localparam int KW = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;
  localparam int SW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int CW = $clog2(DECIMATION + 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {READ, MAC, FINISH, WRITE} state_t;

  state_t        state;
  logic [KW-1:0] tap;
  logic [CW-1:0] read_cnt;
  logic [CW-1:0] stg_cnt;
  logic [CW-1:0] merge_n;
  logic          hist_shift;
  logic          stg_push;
  logic          start;

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] lane_acc;

  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      in_rd_en  = !in_empty && ((state == READ) || (stg_cnt < CW'(DECIMATION)));
      out_wr_en = (state == WRITE) && !out_full;
    end
  end

  assign hist_shift = (state == READ) && in_rd_en;
  // A word read on the WRITE exit cycle bypasses staging and goes straight into the merge.
  assign stg_push   = (state != READ) && in_rd_en && !out_wr_en;
  assign merge_n    = stg_cnt + CW'(in_rd_en);
  assign start      = hist_shift && (read_cnt == CW'(DECIMATION - 1));
  assign out_din    = out_wr_en ? lane_acc : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= READ;
      tap      <= '0;
      read_cnt <= '0;
      stg_cnt  <= '0;
    end else begin
      if (stg_push) stg_cnt <= stg_cnt + CW'(1);
      case (state)
        READ: begin
          if (in_rd_en) begin
            if (read_cnt == CW'(DECIMATION - 1)) begin
              read_cnt <= '0;
              tap      <= '0;
              state    <= MAC;
            end else begin
              read_cnt <= read_cnt + CW'(1);
            end
          end
        end
        MAC: begin
          if (tap == KW'(TAP_NUMBER - 1)) state <= FINISH;
          else                            tap   <= tap + KW'(1);
        end
        FINISH: state <= WRITE;
        WRITE: begin
          if (out_wr_en) begin
            stg_cnt <= '0;
            tap     <= '0;
            if (merge_n == CW'(DECIMATION)) begin
              read_cnt <= '0;
              state    <= MAC;
            end else begin
              read_cnt <= merge_n;
              state    <= READ;
            end
          end
        end
        default: state <= READ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [DATA_WIDTH-1:0] hist   [TAP_NUMBER];
      logic signed [DATA_WIDTH-1:0] merged [TAP_NUMBER];
      logic signed [DATA_WIDTH-1:0] stg    [DECIMATION];
      logic signed [DATA_WIDTH-1:0] sample;
      logic signed [DATA_WIDTH-1:0] prod_reg;
      logic signed [DATA_WIDTH-1:0] prod_next;
      logic signed [DATA_WIDTH-1:0] acc;
      logic signed [PW-1:0]         prod_full;

      assign sample       = in_dout[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_acc[gi] = acc;

      // Staging is newest-first; entries below merge_n take staged words, the rest are the old history shifted.
      always_comb begin
        int src;
        int ofs;
        for (int j = 0; j < TAP_NUMBER; j++) begin
          src = j - int'(merge_n);
          ofs = j - int'(in_rd_en);
          if (src >= 0)     merged[j] = hist[KW'(src)];
          else if (ofs < 0) merged[j] = sample;
          else              merged[j] = stg[SW'(ofs)];
        end
      end

      always_comb begin
        prod_full = PW'(signed'(CONV_COEFF[tap])) * PW'(hist[tap]);
        prod_next = DATA_WIDTH'(prod_full >>> FRAC_BITS);
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int j = 0; j < TAP_NUMBER; j++) hist[j] <= '0;
          for (int j = 0; j < DECIMATION; j++) stg[j] <= '0;
          prod_reg <= '0;
          acc      <= '0;
        end else begin
          if (hist_shift) begin
            hist[0] <= sample;
            for (int j = 1; j < TAP_NUMBER; j++) hist[j] <= hist[j-1];
          end else if (out_wr_en) begin
            for (int j = 0; j < TAP_NUMBER; j++) hist[j] <= merged[j];
          end
          if (stg_push) begin
            stg[0] <= sample;
            for (int j = 1; j < DECIMATION; j++) stg[j] <= stg[j-1];
          end
          // The product is one cycle behind the tap index, so the first MAC cycle only primes prod_reg.
          if (state == MAC) begin
            prod_reg <= prod_next;
            acc      <= (tap == '0) ? '0 : acc + prod_reg;
          end else if (state == FINISH) begin
            acc <= acc + prod_reg;
          end else if (start) begin
            acc <= '0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fir_decim_multi.sv
// Bench for fir_decim_multi: directed table vectors, stall/reset sequences and a
// randomly throttled stream checked through a scoreboard against a reference filter.
module tb_fir_decim_multi;
  localparam int TAPS = 32;
  localparam int DEC  = 8;
  localparam int FB   = 10;
  localparam int CH   = 2;
  localparam int LAT  = TAPS + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_dout = '0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [63:0] out_din;
  logic        out_wr_en;
  logic        out_full = 1'b0;

  always #5 clock = ~clock;

  fir_decim_multi dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_din(out_din), .out_wr_en(out_wr_en), .out_full(out_full)
  );

  typedef struct {
    bit         fresh;
    logic [7:0] m0;
    int         v0;
    logic [7:0] m1;
    int         v1;
    int         e0;
    int         e1;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          coeff [TAPS];
  int          mh [CH][TAPS];
  int          mcnt;
  int          cyc = 0;
  int          rd_count, wr_count;
  int          full_from = -1, full_to = -1;
  bit          use_tab, timing_chk, rand_empty, rand_full;
  logic [63:0] fifo [$];
  logic [63:0] exp_q [$];
  logic [63:0] tab_q [$];
  int          wr_cycs [$];
  int          rd8_cycs [$];
  vec_t        vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] model_out();
    logic [63:0] r;
    longint      p;
    int          acc;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
        p   = longint'(coeff[k]) * longint'(mh[c][k]);
        acc = acc + int'(p >>> FB);
      end
      r[c*32 +: 32] = acc;
    end
    return r;
  endfunction

  task automatic model_push(input logic [63:0] w);
    for (int c = 0; c < CH; c++) begin
      for (int k = TAPS - 1; k > 0; k--) mh[c][k] = mh[c][k-1];
      mh[c][0] = int'(w[c*32 +: 32]);
    end
    mcnt++;
    if (mcnt == DEC) begin
      mcnt = 0;
      rd8_cycs.push_back(cyc);
      if (use_tab && tab_q.size() != 0) exp_q.push_back(tab_q.pop_front());
      else                              exp_q.push_back(model_out());
    end
  endtask

  task automatic clear_bench();
    fifo.delete(); exp_q.delete(); tab_q.delete();
    wr_cycs.delete(); rd8_cycs.delete();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) mh[c][k] = 0;
    mcnt = 0; rd_count = 0; wr_count = 0;
    full_from = -1; full_to = -1;
    use_tab = 0; timing_chk = 0; rand_empty = 0; rand_full = 0;
  endtask

  task automatic step();
    logic [63:0] e;
    @(negedge clock);
    in_empty = (fifo.size() == 0) || (rand_empty && $urandom_range(0, 99) < 40);
    in_dout  = (fifo.size() != 0) ? fifo[0] : {$urandom, $urandom};
    out_full = (cyc >= full_from && cyc < full_to) || (rand_full && $urandom_range(0, 99) < 30);
    #1;
    check("protocol", {61'd0, in_empty & in_rd_en, out_full & out_wr_en, !out_wr_en && (out_din != 0)}, 64'd0);
    if (cyc >= full_from && cyc < full_to) begin
      check("stall_rd_en", 64'(in_rd_en), 64'd0);
      check("stall_out_din", out_din, 64'd0);
    end
    if (cyc == full_to) check("release_write", 64'(out_wr_en), 64'd1);
    if (in_rd_en && !in_empty) begin
      rd_count++;
      model_push(fifo.pop_front());
    end
    if (out_wr_en) begin
      wr_cycs.push_back(cyc);
      $display("[TB] write %0d at cycle %0d ch0=%0d ch1=%0d", wr_count, cyc,
               $signed(out_din[31:0]), $signed(out_din[63:32]));
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", out_din);
      end else begin
        e = exp_q.pop_front();
        check("out_din", out_din, e);
      end
      wr_count++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = '1;
    out_full = 1'b0;
    #1;
    check("reset_rd_en", 64'(in_rd_en), 64'd0);
    check("reset_wr_en", 64'(out_wr_en), 64'd0);
    check("reset_out_din", out_din, 64'd0);
    repeat (2) @(negedge clock);
    clear_bench();
    in_empty = 1'b1;
    reset    = 1'b0;
  endtask

  task automatic finish_test(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d words unread, %0d outputs missing", fifo.size(), exp_q.size());
    end
    repeat (40) step();
    if (use_tab) check("blocks_done", 64'(tab_q.size()), 64'd0);
    if (timing_chk) begin
      if (wr_cycs.size() == 0 || rd8_cycs.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL first_latency: got no write, required %0d cycles", LAT);
      end else begin
        check("first_latency", 64'(wr_cycs[0] - rd8_cycs[0]), 64'(LAT));
        for (int i = 1; i < wr_cycs.size(); i++)
          check("write_period", 64'(wr_cycs[i] - wr_cycs[i-1]), 64'(LAT));
      end
    end
  endtask

  function automatic logic [63:0] small_word();
    int a, b;
    a = int'($urandom_range(0, 8191)) - 4096;
    b = int'($urandom_range(0, 8191)) - 4096;
    return {b, a};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int half [16];
    int n;
    half = '{8, 16, 28, 44, 64, 86, 110, 134, 158, 180, 200, 218, 232, 244, 266, 272};
    for (int k = 0; k < TAPS; k++) coeff[k] = (k < 16) ? half[k] : half[TAPS - 1 - k];

    // constant 1.0 on both lanes, then impulse on ch0 at the 8th sample
    vecs[0]  = '{1'b1, 8'hFF, 1024, 8'hFF, 1024, 490,  490};
    vecs[1]  = '{1'b0, 8'hFF, 1024, 8'hFF, 1024, 2260, 2260};
    vecs[2]  = '{1'b0, 8'hFF, 1024, 8'hFF, 1024, 4030, 4030};
    vecs[3]  = '{1'b0, 8'hFF, 1024, 8'hFF, 1024, 4520, 4520};
    vecs[4]  = '{1'b0, 8'hFF, 1024, 8'hFF, 1024, 4520, 4520};
    vecs[5]  = '{1'b0, 8'hFF, 1024, 8'hFF, 1024, 4520, 4520};
    vecs[6]  = '{1'b1, 8'h80, 1024, 8'h00, 0,    8,    0};
    vecs[7]  = '{1'b0, 8'h00, 0,    8'h00, 0,    158,  0};
    vecs[8]  = '{1'b0, 8'h00, 0,    8'h00, 0,    272,  0};
    vecs[9]  = '{1'b0, 8'h00, 0,    8'h00, 0,    134,  0};
    vecs[10] = '{1'b0, 8'h00, 0,    8'h00, 0,    0,    0};

    clear_bench();
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].fresh) begin
        if (i > 0) finish_test(600);
        do_reset();
        use_tab    = 1;
        timing_chk = 1;
      end
      for (int s = 0; s < DEC; s++)
        fifo.push_back({(vecs[i].m1[s] ? vecs[i].v1 : 0), (vecs[i].m0[s] ? vecs[i].v0 : 0)});
      tab_q.push_back({vecs[i].e1, vecs[i].e0});
    end
    finish_test(600);

    // downstream full for 20 cycles while holding the second result
    do_reset();
    for (int s = 0; s < 40; s++) fifo.push_back(small_word());
    n = 0;
    while (wr_count == 0 && n < 200) begin
      step();
      n++;
    end
    if (wr_count == 0) begin
      n_tests++; n_fail++;
      $display("FAIL stall_first_write: got no write within %0d cycles, required one", n);
    end else begin
      full_from = wr_cycs[0] + LAT;
      full_to   = full_from + 20;
    end
    finish_test(1000);

    // randomly throttled input and output, wide and narrow samples
    do_reset();
    rand_empty = 1;
    rand_full  = 1;
    for (int s = 0; s < 12 * DEC + 3; s++)
      fifo.push_back(((s / DEC) % 2 == 0) ? {$urandom, $urandom} : small_word());
    finish_test(5000);
    check("random_rd_count", 64'(rd_count), 64'(12 * DEC + 3));
    check("random_wr_count", 64'(wr_count), 64'd12);

    // reset at MAC tap 15, then a fresh constant stream
    do_reset();
    for (int s = 0; s < 16; s++) fifo.push_back(small_word());
    n = 0;
    while (rd_count < DEC && n < 100) begin
      step();
      n++;
    end
    check("pre_reset_reads", 64'(rd_count), 64'(DEC));
    repeat (15) step();
    @(negedge clock);
    in_empty = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_rd_en", 64'(in_rd_en), 64'd0);
    check("mid_reset_wr_en", 64'(out_wr_en), 64'd0);
    check("mid_reset_out_din", out_din, 64'd0);
    do_reset();
    use_tab    = 1;
    timing_chk = 1;
    for (int s = 0; s < 2 * DEC; s++) fifo.push_back({32'd1024, 32'd1024});
    tab_q.push_back({32'd490, 32'd490});
    tab_q.push_back({32'd2260, 32'd2260});
    finish_test(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
